// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the 8-bit CPU.
// Fetch-side widths, opcode markers and fetch FSM states.
package cpu_pkg;

  localparam int AW = 8;
  localparam int DW = 8;

  localparam logic [7:0] HLT_OP = 8'h0F;
  localparam int TWO_BYTE_BIT = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_ARG = 3'd2,
    ISSUE     = 3'd3,
    HALT      = 3'd4
  } state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register for the fetch unit.
// Load wins over increment; arithmetic wraps modulo 2^AW.
module pc_reg #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_data_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  // next PC: jump target first, then sequential step
  always_comb begin
    pc_d = pc_q;
    if (ld_i) begin
      pc_d = ld_data_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // PC storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch sequencer: reads 1/2-byte instructions
// and hands opcode+operand to the decoder over valid/ack.
module insn_fetch
  import cpu_pkg::*;
#(
  parameter int            AW           = cpu_pkg::AW,
  parameter int            DW           = cpu_pkg::DW,
  parameter logic [DW-1:0] HLT_OP       = cpu_pkg::HLT_OP,
  parameter int            TWO_BYTE_BIT = cpu_pkg::TWO_BYTE_BIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_rdy,
  input  logic [DW-1:0] mem_din,
  output logic          ins_valid,
  input  logic          ins_ack,
  output logic [DW-1:0] opcode,
  output logic [DW-1:0] operand,
  output logic          two_byte,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_din,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_e        state_q, state_d;
  logic [DW-1:0] opc_q, opc_d;
  logic [DW-1:0] opr_q, opr_d;
  logic          pc_inc;
  logic          pc_ld;

  pc_reg #(.AW(AW)) u_pc (
    .clk       (clk),
    .rst_n     (rst),
    .inc_i     (pc_inc),
    .ld_i      (pc_ld),
    .ld_data_i (pc_din),
    .pc_o      (pc)
  );

  // next state, payload capture and PC control
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    opr_d   = opr_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_ld = 1'b1;
        end else if (run) begin
          state_d = FETCH_OP;
        end
      end
      FETCH_OP: begin
        if (mem_rdy) begin
          opc_d  = mem_din;
          opr_d  = '0;
          pc_inc = 1'b1;
          state_d = mem_din[TWO_BYTE_BIT] ? FETCH_ARG : ISSUE;
        end
      end
      FETCH_ARG: begin
        if (mem_rdy) begin
          opr_d   = mem_din;
          pc_inc  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ins_ack) begin
          pc_ld = pc_load;
          if (opc_q == HLT_OP) begin
            state_d = HALT;
          end else if (run) begin
            state_d = FETCH_OP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and instruction payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      opr_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      opr_q   <= opr_d;
    end
  end

  assign mem_rd    = (state_q == FETCH_OP) ||
                     (state_q == FETCH_ARG);
  assign ins_valid = (state_q == ISSUE);
  assign halted    = (state_q == HALT);
  assign mem_addr  = pc;
  assign opcode    = opc_q;
  assign operand   = opr_q;
  assign two_byte  = opc_q[TWO_BYTE_BIT];

endmodule

// File: tb/tb_insn_fetch.sv
// Bench for insn_fetch: memory/decoder responder plus an
// instruction-stream reference model, directed then random.
module tb_insn_fetch;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_rdy;
  logic [7:0] mem_din;
  logic       ins_valid;
  logic       ins_ack;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       two_byte;
  logic       pc_load;
  logic [7:0] pc_din;
  logic [7:0] pc;
  logic       halted;

  insn_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdy   (mem_rdy),
    .mem_din   (mem_din),
    .ins_valid (ins_valid),
    .ins_ack   (ins_ack),
    .opcode    (opcode),
    .operand   (operand),
    .two_byte  (two_byte),
    .pc_load   (pc_load),
    .pc_din    (pc_din),
    .pc        (pc),
    .halted    (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [256];

  int rdy_dly, ack_dly;
  int rdy_cnt, ack_cnt;
  bit noise, rand_ld, ld_next;
  logic [7:0] ld_tgt;

  logic [7:0] m_pc, m_op, m_arg;
  int m_cnt;

  int n_reads, n_rdcyc, n_issues, n_vcyc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int nxt(input int d);
    return (d < 0) ? int'($urandom_range(0, 3)) : d;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    mem_din = mem[mem_addr];
    mem_rdy = 1'b0;
    ins_ack = 1'b0;
    pc_load = 1'b0;
    pc_din  = 8'($urandom);
    chk("pc", 32'(pc), 32'(m_pc));
    if (mem_rd) begin
      n_rdcyc++;
      chk("addr", 32'(mem_addr), 32'(m_pc));
      if (noise) pc_load = 1'($urandom_range(0, 1));
      if (rdy_cnt == 0) begin
        mem_rdy = 1'b1;
        n_reads++;
        if (m_cnt == 0) begin
          m_op  = mem[m_pc];
          m_arg = 8'h00;
        end else begin
          m_arg = mem[m_pc];
        end
        m_cnt++;
        m_pc = m_pc + 8'd1;
        rdy_cnt = nxt(rdy_dly);
      end else begin
        rdy_cnt--;
      end
    end else if (noise) begin
      mem_rdy = 1'($urandom_range(0, 1));
    end
    if (ins_valid) begin
      n_vcyc++;
      chk("opcode", 32'(opcode), 32'(m_op));
      chk("operand", 32'(operand), 32'(m_arg));
      chk("two_byte", 32'(two_byte), 32'(m_op[7]));
      chk("len", m_cnt, m_op[7] ? 2 : 1);
      if (ack_cnt == 0) begin
        ins_ack = 1'b1;
        n_issues++;
        m_cnt = 0;
        ack_cnt = nxt(ack_dly);
        if (ld_next || (rand_ld && $urandom_range(0, 3) == 0)) begin
          pc_load = 1'b1;
          if (ld_next) pc_din = ld_tgt;
          m_pc = pc_din;
          ld_next = 1'b0;
        end
      end else begin
        ack_cnt--;
        if (noise) pc_load = 1'($urandom_range(0, 1));
      end
    end else if (!mem_rd && !halted && noise) begin
      pc_load = 1'($urandom_range(0, 1));
      if (pc_load) m_pc = pc_din;
    end
  endtask

  task automatic run_until_issue(input int max);
    int base = n_issues;
    int k = 0;
    while (n_issues == base && k < max) begin
      cycle();
      k++;
    end
    chk("issue_seen", n_issues - base, 1);
  endtask

  int r0, c0, v0;

  initial begin
    rst = 1'b0; run = 1'b0;
    mem_rdy = 1'b0; mem_din = 8'h00;
    ins_ack = 1'b0; pc_load = 1'b0; pc_din = 8'h00;
    noise = 0; rand_ld = 0; ld_next = 0; ld_tgt = 8'h00;
    rdy_dly = 0; ack_dly = 0; rdy_cnt = 0; ack_cnt = 0;
    m_pc = 8'h00; m_op = 8'h00; m_arg = 8'h00; m_cnt = 0;
    n_reads = 0; n_rdcyc = 0; n_issues = 0; n_vcyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h12; mem[1] = 8'h85; mem[2] = 8'h3C;
    mem[3] = 8'h81; mem[4] = 8'h22; mem[5] = 8'h01;
    mem[8'h40] = 8'h07;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_opc", 32'(opcode), 0);
    chk("rst_opr", 32'(operand), 0);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_valid", 32'(ins_valid), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_2b", 32'(two_byte), 0);

    // 1-byte instruction, zero-wait
    @(posedge clk);
    #1;
    rst = 1'b1;
    run = 1'b1;
    cycle();
    chk("lat_rd", 32'(mem_rd), 1);
    cycle();
    chk("lat_valid", 32'(ins_valid), 1);
    chk("t1_opc", 32'(opcode), 32'h12);
    chk("t1_pc", 32'(pc), 1);

    // 2-byte instruction
    cycle();
    chk("t2_rd1", 32'(mem_addr), 1);
    cycle();
    chk("t2_rd2", 32'(mem_addr), 2);
    cycle();
    chk("t2_opc", 32'(opcode), 32'h85);
    chk("t2_opr", 32'(operand), 32'h3C);
    chk("t2_2b", 32'(two_byte), 1);
    chk("t2_pc", 32'(pc), 3);

    // slow memory, slow decoder
    rdy_dly = 3; rdy_cnt = 3;
    ack_dly = 4; ack_cnt = 4;
    r0 = n_reads; c0 = n_rdcyc; v0 = n_vcyc;
    run_until_issue(60);
    chk("slow_reads", n_reads - r0, 2);
    chk("slow_rdcyc", n_rdcyc - c0, 8);
    chk("slow_vcyc", n_vcyc - v0, 5);
    rdy_dly = 0; rdy_cnt = 0;
    ack_dly = 0; ack_cnt = 0;

    // jump on ack
    ld_next = 1; ld_tgt = 8'h40;
    run_until_issue(20);
    cycle();
    chk("jump_addr", 32'(mem_addr), 32'h40);

    // wrap-around of a 2-byte instruction at FF
    mem[8'hFF] = 8'h90; mem[0] = 8'hAA;
    ld_next = 1; ld_tgt = 8'hFF;
    run_until_issue(20);
    run_until_issue(20);
    chk("wrap_opc", 32'(opcode), 32'h90);
    chk("wrap_opr", 32'(operand), 32'hAA);
    chk("wrap_pc", 32'(pc), 1);

    // halt
    mem[1] = 8'h0F;
    run_until_issue(20);
    chk("hlt_opc", 32'(opcode), 32'h0F);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("hlt_flag", 32'(halted), 1);
      chk("hlt_rd", 32'(mem_rd), 0);
    end
    run = 1'b0;
    cycle();
    chk("hlt_exit", 32'(halted), 0);
    run = 1'b1;
    run_until_issue(20);
    chk("resume_opc", 32'(opcode), 32'h3C);

    // reset while waiting in the operand read
    mem[3] = 8'h9A; mem[4] = 8'h55;
    rdy_dly = 5; rdy_cnt = 0;
    cycle();
    cycle();
    chk("arg_wait_rd", 32'(mem_rd), 1);
    chk("arg_wait_addr", 32'(mem_addr), 4);
    rst = 1'b0;
    run = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_rd", 32'(mem_rd), 0);
    chk("mid_rst_valid", 32'(ins_valid), 0);
    chk("mid_rst_opc", 32'(opcode), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_pc = 8'h00; m_cnt = 0;
    rdy_dly = 0; rdy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_rst_valid", 32'(ins_valid), 0);
      chk("post_rst_rd", 32'(mem_rd), 0);
    end

    // randomized traffic
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (mem[i] == 8'h0F) mem[i] = 8'h1F;
    end
    rdy_dly = -1; ack_dly = -1;
    noise = 1; rand_ld = 1;
    begin
      int base = n_issues;
      int k = 0;
      while (n_issues < base + 150 && k < 6000) begin
        run = ($urandom_range(0, 7) != 0);
        cycle();
        k++;
      end
      chk("rand_issues", n_issues - base, 150);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/insn_fetch.md
Name: insn_fetch

Overview:
- Instruction fetch sequencer for the 8-bit CPU; the producer side of the operand path.
- Reads 1- or 2-byte instructions from memory over a ready-handshaked read port and assembles opcode plus low-byte operand.
- Presents the assembled instruction to the controller/decoder with a valid/ack handshake.
- Owns the PC, its increment, jump loading and wrap-around.

Parameters:
- AW, 8, address / PC width
- DW, 8, data / opcode / operand width
- HLT_OP, 8'h0F, opcode that stops fetching after issue
- TWO_BYTE_BIT, 7, opcode bit that marks a 2-byte instruction when 1

Ports:
- clk  input  1  system clock, active rising edge
- rst  input  1  asynchronous active-low reset; 0 = reset, 1 = normal operation
- run  input  1  fetch enable from controller
- mem_addr  output  AW  read address, equals pc while mem_rd=1
- mem_rd  output  1  read request
- mem_rdy  input  1  memory ack; mem_din valid in the same cycle
- mem_din  input  DW  read data
- ins_valid  output  1  opcode/operand/two_byte valid
- ins_ack  input  1  decoder consumes instruction
- opcode  output  DW  fetched opcode
- operand  output  DW  second byte; 0 for 1-byte instructions
- two_byte  output  1  opcode[TWO_BYTE_BIT]
- pc_load  input  1  jump request
- pc_din  input  AW  jump target
- pc  output  AW  current PC
- halted  output  1  high in HALT state

Behaviour:
- Reset (rst=0, async): state=IDLE; pc=0, opcode=0, operand=0. All outputs low/0.
- Moore outputs decoded from state only:
  - mem_rd=1 in FETCH_OP and FETCH_ARG.
  - ins_valid=1 in ISSUE.
  - halted=1 in HALT.
- mem_addr=pc always.
- IDLE:
  - pc_load=1 -> pc<=pc_din (this has priority over everything else in IDLE).
  - Else run=1 -> FETCH_OP next cycle.
- FETCH_OP:
  - Hold mem_rd until mem_rdy.
  - On mem_rdy: opcode<=mem_din, pc<=pc+1, operand<=0.
  - Next state is FETCH_ARG if mem_din[TWO_BYTE_BIT]=1, else ISSUE.
- FETCH_ARG:
  - Hold mem_rd until mem_rdy.
  - On mem_rdy: operand<=mem_din, pc<=pc+1; next state ISSUE.
- ISSUE:
  - Hold ins_valid and all payload stable until ins_ack.
  - On ins_ack: pc<=pc_din if pc_load=1, else pc unchanged.
  - Next state: HALT if opcode==HLT_OP; else FETCH_OP if run=1; else IDLE.
- HALT:
  - No memory reads.
  - run=0 -> IDLE. Resuming requires a run 0->1 sequence or reset.
- PC arithmetic is modulo 2^AW: 8'hFF+1 = 8'h00. A 2-byte opcode at 8'hFF reads its operand from 8'h00.
- run deassert mid-fetch: the current instruction completes through ISSUE; only then is IDLE entered. Memory handshakes are never abandoned.
- pc_load is ignored in FETCH_OP, FETCH_ARG and HALT, and in ISSUE without ins_ack.
- mem_rdy while mem_rd=0 is ignored.
- Latency (zero-wait memory, ack immediate):
  - 1-byte instruction: 1 cycle FETCH_OP + 1 cycle ISSUE.
  - 2-byte instruction: 3 cycles.
  - ins_valid rises the cycle after the last mem_rdy.
- Reset mid-operation: immediate return to IDLE with pc=0. No partial instruction is ever issued.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding constants: IDLE, FETCH_OP, FETCH_ARG, ISSUE, HALT (3-bit);
  - HLT_OP and TWO_BYTE_BIT;
  - data and address widths.
- Natural sub-module: pc_reg (PC register with async active-low reset, increment enable, load enable, load data; load has priority over increment).
- FSM and opcode/operand registers stay in insn_fetch.

Test Plan:
- Reset, run=1, zero-wait memory with mem[0]=8'h12 -> opcode=8'h12, operand=0, two_byte=0; ins_valid on the 2nd cycle after run; pc=1.
- mem[1]=8'h85, mem[2]=8'h3C -> two reads at addr 1 then 2; opcode=8'h85, operand=8'h3C, two_byte=1; pc=3.
- mem_rdy delayed 3 cycles, ins_ack delayed 4 cycles -> mem_rd held with addr stable during the wait; payload stable while ins_valid=1; no extra reads.
- In ISSUE, ins_ack=1 with pc_load=1, pc_din=8'h40 -> next mem_addr=8'h40.
- pc=8'hFF with mem[FF]=8'h90, mem[00]=8'hAA -> operand=8'hAA; pc wraps to 8'h01.
- Fetch mem[n]=8'h0F -> after ack, halted=1 and mem_rd stays 0. Separately, rst pulsed low mid-FETCH_ARG -> pc=0, state IDLE, no ins_valid.
